// File: rtl/serial_parallel_aligner_pkg.sv
// rtl/serial_parallel_aligner_pkg.sv - shared byte width, comma constant and aligner state encoding
package serial_parallel_aligner_pkg;

  localparam int BYTE_W = 8;

  // Shared with the upstream serializer so both ends agree on the idle byte.
  localparam logic [BYTE_W-1:0] COMMA_K285 = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_parallel_aligner_if.sv
// rtl/serial_parallel_aligner_if.sv - serial input and parallel output bundle of the aligner
interface serial_parallel_aligner_if;
  import serial_parallel_aligner_pkg::BYTE_W;

  logic              DATA_IN;
  logic              VALID_IN;
  logic [BYTE_W-1:0] DATA_OUT;
  logic              VALID_OUT;
  logic              ACTIVE;
  logic              COMMA_DET;

  modport master (
    output DATA_IN, VALID_IN,
    input  DATA_OUT, VALID_OUT, ACTIVE, COMMA_DET
  );

  modport slave (
    input  DATA_IN, VALID_IN,
    output DATA_OUT, VALID_OUT, ACTIVE, COMMA_DET
  );

endinterface

// File: rtl/serial_shift_window.sv
// rtl/serial_shift_window.sv - LSB-first shift history, fill tracking and comma comparator
module serial_shift_window
  import serial_parallel_aligner_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA = COMMA_K285
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              data_in,
  input  logic              valid_in,
  output logic [BYTE_W-1:0] window,
  output logic              comma_hit
);

  // Only the seven most recent bits are kept: the oldest bit of a full byte
  // register would be shifted out before it could ever be compared.
  logic [BYTE_W-2:0] hist;
  logic [2:0]        fill;

  assign window    = {data_in, hist};
  assign comma_hit = valid_in && (fill == 3'd7) && (window == COMMA);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hist <= '0;
      fill <= '0;
    end else if (!valid_in) begin
      fill <= '0;
    end else begin
      hist <= window[BYTE_W-1:1];
      if (fill != 3'd7) begin
        fill <= fill + 3'd1;
      end
    end
  end

endmodule

// File: rtl/serial_parallel_aligner.sv
// rtl/serial_parallel_aligner.sv - comma-locked serial-to-parallel byte aligner
module serial_parallel_aligner
  import serial_parallel_aligner_pkg::*;
#(
  parameter int                    DATA_WIDTH = BYTE_W,
  parameter logic [DATA_WIDTH-1:0] COMMA      = COMMA_K285,
  parameter int                    LOCK_COUNT = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  serial_parallel_aligner_if.slave bus
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  logic [DATA_WIDTH-1:0] window;
  logic                  comma_hit;
  state_t                state;
  logic [2:0]            bit_cnt;
  logic [3:0]            comma_cnt;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  valid_out_r;
  logic                  active_r;
  logic                  comma_det_r;

  serial_shift_window #(
    .COMMA(COMMA)
  ) u_window (
    .CLK      (CLK),
    .RESET    (RESET),
    .data_in  (bus.DATA_IN),
    .valid_in (bus.VALID_IN),
    .window   (window),
    .comma_hit(comma_hit)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= SEARCH;
      bit_cnt     <= '0;
      comma_cnt   <= '0;
      data_out_r  <= '0;
      valid_out_r <= 1'b0;
      active_r    <= 1'b0;
      comma_det_r <= 1'b0;
    end else begin
      valid_out_r <= 1'b0;
      comma_det_r <= 1'b0;
      if (!bus.VALID_IN) begin
        state     <= SEARCH;
        active_r  <= 1'b0;
        bit_cnt   <= '0;
        comma_cnt <= '0;
      end else begin
        case (state)
          SEARCH: begin
            if (comma_hit) begin
              comma_det_r <= 1'b1;
              bit_cnt     <= '0;
              comma_cnt   <= 4'd1;
              state       <= (LOCK_N == 4'd1) ? ACTIVE : SYNC;
              active_r    <= (LOCK_N == 4'd1);
            end
          end
          SYNC: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (comma_hit) begin
                comma_det_r <= 1'b1;
                comma_cnt   <= comma_cnt + 4'd1;
                if (comma_cnt + 4'd1 == LOCK_N) begin
                  state    <= ACTIVE;
                  active_r <= 1'b1;
                end
              end else begin
                // Window stays full, so bit-level search resumes on the next bit.
                state     <= SEARCH;
                comma_cnt <= '0;
              end
            end
          end
          ACTIVE: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (comma_hit) begin
                comma_det_r <= 1'b1;
              end else begin
                data_out_r  <= window;
                valid_out_r <= 1'b1;
              end
            end
          end
          default: begin
            state    <= SEARCH;
            active_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.DATA_OUT  = data_out_r;
  assign bus.VALID_OUT = valid_out_r;
  assign bus.ACTIVE    = active_r;
  assign bus.COMMA_DET = comma_det_r;

endmodule
